// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// cp0_timer : MIPS coprocessor-0 (SR/Cause/EPC/PRId) with Count/Compare timer
// Rev 1.0
// ============================================================================
module cp0_timer #(
  parameter int          N_INT     = 5,
  parameter logic [31:0] PRID_VAL  = 32'h0000_0000,
  parameter bit          TIMER_EN  = 1'b1,
  parameter int          COUNT_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE,
  input  logic [4:0]       regAddr,
  input  logic [31:0]      dataIn,
  input  logic [31:0]      PCnow,
  input  logic [N_INT-1:0] INTcodeIn,
  input  logic [4:0]       EXCcodeIn,
  input  logic             if_delaybanch,
  input  logic             if_eret,
  output logic [31:0]      EPCout,
  output logic [31:0]      dataOut,
  output logic             Req,
  output logic             timer_irq
);

  localparam logic [4:0]  c_ADDR_COUNT   = 5'd9;
  localparam logic [4:0]  c_ADDR_COMPARE = 5'd11;
  localparam logic [4:0]  c_ADDR_SR      = 5'd12;
  localparam logic [4:0]  c_ADDR_CAUSE   = 5'd13;
  localparam logic [4:0]  c_ADDR_EPC     = 5'd14;
  localparam logic [4:0]  c_ADDR_PRID    = 5'd15;
  localparam logic [5:0]  c_IM_MASK      = 6'((7'd1 << (N_INT + 1)) - 7'd1);
  localparam logic [31:0] c_SR_MASK      = {16'h0000, c_IM_MASK, 8'h00, 2'b11};
  localparam logic [7:0]  c_PRESC_MAX    = 8'(COUNT_DIV - 1);

  logic [31:0] sr_q, sr_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        tpend_q;

  logic [5:0]  w_ip_vec;
  logic        w_exl;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_wr;

  // The timer line sits directly above the external lines.
  assign w_ip_vec  = 6'({tpend_q, INTcodeIn});
  assign w_exl     = sr_q[1];
  assign w_int_req = ~w_exl & sr_q[0] & (|(w_ip_vec & sr_q[15:10]));
  assign w_exc_req = ~w_exl & (EXCcodeIn != 5'd0);
  assign Req       = w_int_req | w_exc_req;
  assign w_wr      = WE & ~Req;

  always_comb begin
    sr_d  = sr_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (Req) begin
      sr_d[1] = 1'b1;
      bd_d    = if_delaybanch;
      epc_d   = if_delaybanch ? (PCnow - 32'd4) : PCnow;
      exc_d   = w_int_req ? 5'd0 : EXCcodeIn;
    end else begin
      if (w_wr && regAddr == c_ADDR_SR)  sr_d  = dataIn & c_SR_MASK;
      if (w_wr && regAddr == c_ADDR_EPC) epc_d = {dataIn[31:2], 2'b00};
      if (if_eret)                       sr_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      sr_q  <= sr_d;
      bd_q  <= bd_d;
      ip_q  <= w_ip_vec;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  if (TIMER_EN) begin : g_timer
    logic [7:0] presc_q;
    logic       w_wr_count;
    logic       w_wr_compare;

    assign w_wr_count   = w_wr & (regAddr == c_ADDR_COUNT);
    assign w_wr_compare = w_wr & (regAddr == c_ADDR_COMPARE);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        presc_q   <= '0;
        count_q   <= '0;
        compare_q <= 32'hFFFF_FFFF;
        tpend_q   <= 1'b0;
      end else begin
        if (w_wr_count) begin
          presc_q <= '0;
          count_q <= dataIn;
        end else if (presc_q == c_PRESC_MAX) begin
          presc_q <= '0;
          count_q <= count_q + 32'd1;
        end else begin
          presc_q <= presc_q + 8'd1;
        end

        // A Compare write acknowledges the timer and beats a same-cycle match.
        if (w_wr_compare) begin
          compare_q <= dataIn;
          tpend_q   <= 1'b0;
        end else if (count_q == compare_q) begin
          tpend_q   <= 1'b1;
        end
      end
    end
  end else begin : g_no_timer
    assign count_q   = '0;
    assign compare_q = '0;
    assign tpend_q   = 1'b0;
  end

  always_comb begin
    dataOut = '0;
    case (regAddr)
      c_ADDR_COUNT:   dataOut = count_q;
      c_ADDR_COMPARE: dataOut = compare_q;
      c_ADDR_SR:      dataOut = sr_q;
      c_ADDR_CAUSE:   dataOut = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b00};
      c_ADDR_EPC:     dataOut = epc_q;
      c_ADDR_PRID:    dataOut = PRID_VAL;
      default:        dataOut = '0;
    endcase
  end

  assign EPCout    = epc_q;
  assign timer_irq = tpend_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_timer.sv
`default_nettype none
// tb_cp0_timer: directed scenarios on several parameterisations plus a
// randomized run of the default configuration against a behavioural model.
module tb_cp0_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [4:0]  regAddr;
  logic [31:0] dataIn;
  logic [31:0] PCnow;
  logic [4:0]  EXCcodeIn;
  logic        dly;
  logic        eret;
  logic [4:0]  int5;
  logic [1:0]  int2;

  logic [31:0] epc_a, dout_a, epc_d, dout_d, epc_n, dout_n, epc_t, dout_t;
  logic        req_a, tirq_a, req_d, tirq_d, req_n, tirq_n, req_t, tirq_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp0_timer dut_a (
    .clk(clk), .reset(reset), .WE(WE), .regAddr(regAddr), .dataIn(dataIn), .PCnow(PCnow),
    .INTcodeIn(int5), .EXCcodeIn(EXCcodeIn), .if_delaybanch(dly), .if_eret(eret),
    .EPCout(epc_a), .dataOut(dout_a), .Req(req_a), .timer_irq(tirq_a));

  cp0_timer #(.COUNT_DIV(4)) dut_d (
    .clk(clk), .reset(reset), .WE(WE), .regAddr(regAddr), .dataIn(dataIn), .PCnow(PCnow),
    .INTcodeIn(int5), .EXCcodeIn(EXCcodeIn), .if_delaybanch(dly), .if_eret(eret),
    .EPCout(epc_d), .dataOut(dout_d), .Req(req_d), .timer_irq(tirq_d));

  cp0_timer #(.N_INT(2)) dut_n (
    .clk(clk), .reset(reset), .WE(WE), .regAddr(regAddr), .dataIn(dataIn), .PCnow(PCnow),
    .INTcodeIn(int2), .EXCcodeIn(EXCcodeIn), .if_delaybanch(dly), .if_eret(eret),
    .EPCout(epc_n), .dataOut(dout_n), .Req(req_n), .timer_irq(tirq_n));

  cp0_timer #(.TIMER_EN(1'b0)) dut_t (
    .clk(clk), .reset(reset), .WE(WE), .regAddr(regAddr), .dataIn(dataIn), .PCnow(PCnow),
    .INTcodeIn(int5), .EXCcodeIn(EXCcodeIn), .if_delaybanch(dly), .if_eret(eret),
    .EPCout(epc_t), .dataOut(dout_t), .Req(req_t), .timer_irq(tirq_t));

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE = 1'b0; regAddr = 5'd0; dataIn = '0; PCnow = '0;
    EXCcodeIn = '0; dly = 1'b0; eret = 1'b0; int5 = '0; int2 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    #2;
    reset = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a);
    WE = 1'b0;
    regAddr = a;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WE = 1'b1; regAddr = a; dataIn = d;
    step();
    WE = 1'b0;
  endtask

  // ---------------- behavioural model of the default configuration ----------------
  logic [31:0] m_sr, m_epc, m_count, m_cmp;
  logic        m_bd, m_tpend;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;
  int unsigned m_ticks;

  task automatic model_reset();
    m_sr = 0; m_epc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
    m_bd = 0; m_tpend = 0; m_ip = 0; m_exc = 0; m_ticks = 0;
  endtask

  function automatic logic [5:0] m_pending();
    return {m_tpend, int5};
  endfunction

  function automatic logic m_int();
    logic any = 1'b0;
    for (int j = 0; j < 6; j++)
      if (m_pending()[j] && m_sr[10 + j]) any = 1'b1;
    return !m_sr[1] && m_sr[0] && any;
  endfunction

  function automatic logic m_req();
    return m_int() || (!m_sr[1] && EXCcodeIn != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:  return m_count;
      5'd11: return m_cmp;
      5'd12: return m_sr;
      5'd13: return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clock();
    logic        req = m_req();
    logic        intr = m_int();
    logic [31:0] old_count = m_count;
    logic [31:0] old_cmp = m_cmp;
    logic        wr_ok = WE && !req;
    m_ip = m_pending();
    if (req) begin
      m_sr  = m_sr | 32'h2;
      m_bd  = dly;
      m_epc = dly ? PCnow - 4 : PCnow;
      m_exc = intr ? 5'd0 : EXCcodeIn;
    end else begin
      if (wr_ok && regAddr == 12) m_sr = dataIn & 32'h0000_FC03;
      if (wr_ok && regAddr == 14) m_epc = dataIn & ~32'h3;
      if (eret) m_sr = m_sr & ~32'h2;
    end
    if (wr_ok && regAddr == 9) begin
      m_count = dataIn;
      m_ticks = 0;
    end else begin
      m_ticks++;
      if (m_ticks % 1 == 0) m_count = m_count + 1;
    end
    if (wr_ok && regAddr == 11) begin
      m_cmp = dataIn;
      m_tpend = 0;
    end else if (old_count == old_cmp) begin
      m_tpend = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    wr(5'd14, 32'h0000_1237);
    n_cmp++; if (epc_a !== 32'h0000_1234) begin n_err++; $display("FAIL epc_write_mask: got %h expected %h", epc_a, 32'h0000_1234); end
    wr(5'd11, 32'd2);
    step();
    n_cmp++; if (tirq_a !== 1'b1) begin n_err++; $display("FAIL pre_reset_tirq: got %b expected 1", tirq_a); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (epc_a !== 32'd0) begin n_err++; $display("FAIL reset_epc: got %h expected 0", epc_a); end
    n_cmp++; if (tirq_a !== 1'b0) begin n_err++; $display("FAIL reset_tirq: got %b expected 0", tirq_a); end
    n_cmp++; if (req_a !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", req_a); end
    rd(5'd12);
    n_cmp++; if (dout_a !== 32'd0) begin n_err++; $display("FAIL reset_sr: got %h expected 0", dout_a); end
    rd(5'd9);
    n_cmp++; if (dout_a !== 32'd0) begin n_err++; $display("FAIL reset_count: got %h expected 0", dout_a); end
    rd(5'd11);
    n_cmp++; if (dout_a !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_compare: got %h expected ffffffff", dout_a); end
    rd(5'd13);
    n_cmp++; if (dout_a !== 32'd0) begin n_err++; $display("FAIL reset_cause: got %h expected 0", dout_a); end
    reset = 1'b1;
  endtask

  task automatic test_timer();
    do_reset();
    PCnow = 32'h0000_1000;
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd10);
    PCnow = 32'h0000_1000;
    for (int i = 2; i < 10; i++) step();
    rd(5'd9);
    n_cmp++; if (dout_a !== 32'd10) begin n_err++; $display("FAIL timer_count10: got %h expected %h", dout_a, 32'd10); end
    n_cmp++; if (tirq_a !== 1'b0) begin n_err++; $display("FAIL timer_not_yet: got %b expected 0", tirq_a); end
    step();
    n_cmp++; if (tirq_a !== 1'b1) begin n_err++; $display("FAIL timer_irq_set: got %b expected 1", tirq_a); end
    n_cmp++; if (req_a !== 1'b1) begin n_err++; $display("FAIL timer_req: got %b expected 1", req_a); end
    step();
    rd(5'd12);
    n_cmp++; if (dout_a !== 32'h0000_8003) begin n_err++; $display("FAIL timer_sr_exl: got %h expected %h", dout_a, 32'h0000_8003); end
    n_cmp++; if (req_a !== 1'b0) begin n_err++; $display("FAIL timer_req_masked: got %b expected 0", req_a); end
    rd(5'd13);
    n_cmp++; if (dout_a !== 32'h0000_8000) begin n_err++; $display("FAIL timer_cause: got %h expected %h", dout_a, 32'h0000_8000); end
    n_cmp++; if (epc_a !== 32'h0000_1000) begin n_err++; $display("FAIL timer_epc: got %h expected %h", epc_a, 32'h0000_1000); end
  endtask

  task automatic test_exception_eret();
    do_reset();
    PCnow = 32'h0000_3000; dly = 1'b1; EXCcodeIn = 5'd4;
    WE = 1'b1; regAddr = 5'd14; dataIn = 32'h0000_1234;
    #1;
    n_cmp++; if (req_a !== 1'b1) begin n_err++; $display("FAIL exc_req: got %b expected 1", req_a); end
    step();
    WE = 1'b0; EXCcodeIn = 5'd0; dly = 1'b0;
    n_cmp++; if (epc_a !== 32'h0000_2FFC) begin n_err++; $display("FAIL exc_epc_bd: got %h expected %h", epc_a, 32'h0000_2FFC); end
    rd(5'd13);
    n_cmp++; if (dout_a !== 32'h8000_0010) begin n_err++; $display("FAIL exc_cause: got %h expected %h", dout_a, 32'h8000_0010); end
    rd(5'd12);
    n_cmp++; if (dout_a !== 32'h0000_0002) begin n_err++; $display("FAIL exc_exl: got %h expected 2", dout_a); end
    EXCcodeIn = 5'd10;
    #1;
    n_cmp++; if (req_a !== 1'b0) begin n_err++; $display("FAIL exc_nested_req: got %b expected 0", req_a); end
    step();
    EXCcodeIn = 5'd0;
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(5'd12);
    n_cmp++; if (dout_a !== 32'd0) begin n_err++; $display("FAIL eret_clears_exl: got %h expected 0", dout_a); end
    eret = 1'b1; EXCcodeIn = 5'd12; PCnow = 32'h0000_4000;
    #1;
    n_cmp++; if (req_a !== 1'b1) begin n_err++; $display("FAIL eret_exc_req: got %b expected 1", req_a); end
    step();
    eret = 1'b0; EXCcodeIn = 5'd0;
    rd(5'd12);
    n_cmp++; if (dout_a !== 32'h0000_0002) begin n_err++; $display("FAIL eret_loses_exl: got %h expected 2", dout_a); end
    rd(5'd13);
    n_cmp++; if (dout_a !== 32'h0000_0030) begin n_err++; $display("FAIL eret_exc_cause: got %h expected %h", dout_a, 32'h0000_0030); end
  endtask

  task automatic test_compare_write();
    do_reset();
    wr(5'd11, 32'd5);
    for (int i = 1; i < 5; i++) step();
    n_cmp++; if (tirq_a !== 1'b0) begin n_err++; $display("FAIL cmp_early: got %b expected 0", tirq_a); end
    step();
    n_cmp++; if (tirq_a !== 1'b1) begin n_err++; $display("FAIL cmp_latency: got %b expected 1", tirq_a); end
    wr(5'd9, 32'd5);
    rd(5'd9);
    n_cmp++; if (dout_a !== 32'd5) begin n_err++; $display("FAIL count_write_wins: got %h expected 5", dout_a); end
    wr(5'd11, 32'h20);
    n_cmp++; if (tirq_a !== 1'b0) begin n_err++; $display("FAIL cmp_write_wins: got %b expected 0", tirq_a); end
    rd(5'd11);
    n_cmp++; if (dout_a !== 32'h20) begin n_err++; $display("FAIL cmp_readback: got %h expected 20", dout_a); end
    step();
    n_cmp++; if (tirq_a !== 1'b0) begin n_err++; $display("FAIL cmp_stays_clear: got %b expected 0", tirq_a); end
  endtask

  task automatic test_prescaler();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd(5'd9);
      exp = (i == 4) ? 32'd1 : 32'd0;
      n_cmp++; if (dout_d !== exp) begin n_err++; $display("FAIL presc_count[%0d]: got %h expected %h", i, dout_d, exp); end
      if (i < 4) step();
    end
    wr(5'd9, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) step();
    rd(5'd9);
    n_cmp++; if (dout_d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL presc_hold: got %h expected ffffffff", dout_d); end
    step();
    rd(5'd9);
    n_cmp++; if (dout_d !== 32'd0) begin n_err++; $display("FAIL presc_wrap: got %h expected 0", dout_d); end
  endtask

  task automatic test_nint2();
    do_reset();
    int2 = 2'b10;
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12);
    n_cmp++; if (dout_n !== 32'h0000_1C03) begin n_err++; $display("FAIL n2_sr_mask: got %h expected %h", dout_n, 32'h0000_1C03); end
    wr(5'd12, 32'h0000_0401);
    n_cmp++; if (req_n !== 1'b0) begin n_err++; $display("FAIL n2_req_masked: got %b expected 0", req_n); end
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13);
    n_cmp++; if (dout_n !== 32'h0000_0800) begin n_err++; $display("FAIL n2_cause_ro: got %h expected %h", dout_n, 32'h0000_0800); end
    wr(5'd12, 32'h0000_0C01);
    n_cmp++; if (req_n !== 1'b1) begin n_err++; $display("FAIL n2_req: got %b expected 1", req_n); end
    int2 = 2'b00;
  endtask

  task automatic test_no_timer();
    do_reset();
    wr(5'd11, 32'd3);
    wr(5'd9, 32'd3);
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (tirq_t !== 1'b0) begin n_err++; $display("FAIL nt_tirq: got %b expected 0", tirq_t); end
    n_cmp++; if (tirq_a !== 1'b1) begin n_err++; $display("FAIL nt_ref_tirq: got %b expected 1", tirq_a); end
    rd(5'd9);
    n_cmp++; if (dout_t !== 32'd0) begin n_err++; $display("FAIL nt_count: got %h expected 0", dout_t); end
    rd(5'd11);
    n_cmp++; if (dout_t !== 32'd0) begin n_err++; $display("FAIL nt_compare: got %h expected 0", dout_t); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [4:0]  addrs [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      WE = ($urandom_range(0, 3) == 0);
      regAddr = addrs[$urandom_range(0, 6)];
      dataIn = $urandom;
      if (regAddr == 5'd11) dataIn = m_count + 32'($urandom_range(0, 5));
      if (regAddr == 5'd9 && $urandom_range(0, 1) == 1) dataIn = m_cmp - 32'($urandom_range(0, 3));
      PCnow = $urandom & ~32'h3;
      int5 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      EXCcodeIn = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      eret = ($urandom_range(0, 5) == 0);
      dly = 1'($urandom);
      #1;
      exp = m_read(regAddr);
      n_cmp++; if (req_a !== m_req()) begin n_err++; $display("FAIL rnd_req[%0d]: got %b expected %b", c, req_a, m_req()); end
      n_cmp++; if (dout_a !== exp) begin n_err++; $display("FAIL rnd_dout[%0d] addr %0d: got %h expected %h", c, regAddr, dout_a, exp); end
      n_cmp++; if (epc_a !== m_epc) begin n_err++; $display("FAIL rnd_epc[%0d]: got %h expected %h", c, epc_a, m_epc); end
      n_cmp++; if (tirq_a !== m_tpend) begin n_err++; $display("FAIL rnd_tirq[%0d]: got %b expected %b", c, tirq_a, m_tpend); end
      step();
      model_clock();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_timer();
    test_exception_eret();
    test_compare_write();
    test_prescaler();
    test_nint2();
    test_no_timer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
